// File: rtl/dual_port_mem_req_ctrl.sv
// Request controller for one port of the dual-port memory bank.
// Turns a valid/ready command stream into bank en/we/addr/din, captures the
// bank's one-cycle-latency read data into a small response FIFO and returns it
// on a valid/ready response stream. Reads are credit-limited so the FIFO
// can never overflow under response backpressure.
module dual_port_mem_req_ctrl #(
    parameter int WIDTH     = 8,
    parameter int ADDR      = 3,
    parameter int RSP_DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_we,
    input  logic [ADDR-1:0]  i_cmd_addr,
    input  logic [WIDTH-1:0] i_cmd_wdata,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_mem_en,
    output logic             o_mem_we,
    output logic [ADDR-1:0]  o_mem_addr,
    output logic [WIDTH-1:0] o_mem_din,
    input  logic [WIDTH-1:0] i_mem_dout,
    output logic             o_idle
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(RSP_DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(RSP_DEPTH);

    logic [WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    fifo_count;
    logic             inflight;

    logic             accept;
    logic             pop;
    logic             push;
    logic [CW:0]      credits_used;
    logic [CW:0]      credits_after_pop;

    assign pop  = o_rsp_valid & i_rsp_ready;
    assign push = inflight;

    // An in-flight read already owns a FIFO slot; a same-cycle pop frees one,
    // which is why i_rsp_ready reaches o_cmd_ready combinationally.
    assign credits_used      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign credits_after_pop = credits_used - {{CW{1'b0}}, pop};

    // Command acceptance: writes never throttled, reads only with a free credit
    always_comb begin
        o_cmd_ready = 1'b0;
        if (i_rst_n) begin
            o_cmd_ready = i_cmd_we | (credits_after_pop < DEPTH_C);
        end
    end

    assign accept     = i_cmd_valid & o_cmd_ready;
    assign o_mem_en   = accept;
    assign o_mem_we   = accept & i_cmd_we;
    assign o_mem_addr = i_cmd_addr;
    assign o_mem_din  = i_cmd_wdata;

    assign o_rsp_valid = (fifo_count != '0);
    assign o_rsp_data  = fifo_mem[rd_ptr];
    assign o_idle      = (fifo_count == '0) & ~inflight;

    // Read tracking and response FIFO; bank data is captured the cycle after a read issue
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            inflight   <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            inflight <= accept & ~i_cmd_we;
            if (push) begin
                fifo_mem[wr_ptr] <= i_mem_dout;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Credit scheme guarantees a push never lands on a full FIFO without a pop
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(push && !pop && fifo_count == FULL_C))
        else $error("response FIFO overflow");

endmodule

// File: tb/tb_dual_port_mem_req_ctrl.sv
// Directed bench for dual_port_mem_req_ctrl with a behavioural read-first
// bank (one-cycle read latency, no reset) wired behind the controller.
module tb_dual_port_mem_req_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       mem_en;
    logic       mem_we;
    logic [2:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       idle;

    int total = 0;
    int bad   = 0;

    logic [7:0] bank [8];
    logic [7:0] shadow [8];

    dual_port_mem_req_ctrl #(.WIDTH(8), .ADDR(3), .RSP_DEPTH(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_wdata (cmd_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_din   (mem_din),
        .i_mem_dout  (mem_dout),
        .o_idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first bank port: dout registers old contents at the enabling edge
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= bank[mem_addr];
            if (mem_we) bank[mem_addr] <= mem_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] a, input logic [7:0] d);
        cmd_valid = v;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d);
        mid();
        chk("wr_ready", cmd_ready, 1);
        chk("wr_mem_we", mem_we, 1);
        shadow[a] = d;
        tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 3'd0, 8'h00);

        // reset held with a command pending
        tick();
        for (int r = 0; r < 3; r++) begin
            mid();
            chk("rst_mem_en", mem_en, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_idle", idle, 1);
            tick();
        end
        chk("rst_rsp_data", rsp_data, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 8'h00);

        // write 3 <- A5, then read 3: data visible 2 edges after accept
        drive(1'b1, 1'b1, 3'd3, 8'hA5);
        mid();
        chk("wr_ready", cmd_ready, 1);
        chk("wr_en", mem_en, 1);
        chk("wr_we", mem_we, 1);
        tick();
        drive(1'b1, 1'b0, 3'd3, 8'h00);
        mid();
        chk("rd_ready", cmd_ready, 1);
        chk("rd_en", mem_en, 1);
        chk("rd_we", mem_we, 0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        mid();
        chk("rd_lat1_valid", rsp_valid, 0);
        chk("rd_lat1_idle", idle, 0);
        tick();
        mid();
        chk("rd_lat2_valid", rsp_valid, 1);
        chk("rd_lat2_data", rsp_data, 8'hA5);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        mid();
        chk("rd_done_valid", rsp_valid, 0);
        chk("rd_done_idle", idle, 1);

        // preload 0x10..0x17, one write per cycle
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 3'(i), 8'(8'h10 + i));
            mid();
            chk("pre_ready", cmd_ready, 1);
            shadow[i] = 8'(8'h10 + i);
            tick();
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00);

        // streaming reads with consumer always ready
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive(1'b1, 1'b0, 3'(c), 8'h00);
            else       drive(1'b0, 1'b0, 3'd0, 8'h00);
            mid();
            if (c < 8) chk("stream_ready", cmd_ready, 1);
            if (c >= 2) begin
                chk("stream_valid", rsp_valid, 1);
                chk("stream_data", rsp_data, 8'h10 + c - 2);
            end
            tick();
        end
        mid();
        chk("stream_idle", idle, 1);
        tick();

        // backpressure: only two reads fit, writes still flow
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 3'd1, 8'h00);
        mid(); chk("bp_rd0_ready", cmd_ready, 1); tick();
        drive(1'b1, 1'b0, 3'd2, 8'h00);
        mid(); chk("bp_rd1_ready", cmd_ready, 1); tick();
        drive(1'b1, 1'b0, 3'd4, 8'h00);
        mid(); chk("bp_rd2_ready", cmd_ready, 0); chk("bp_rd2_en", mem_en, 0); tick();
        mid(); chk("bp_rd3_ready", cmd_ready, 0);
        chk("bp_head_valid", rsp_valid, 1);
        chk("bp_head_data", rsp_data, 8'h11);
        drive(1'b1, 1'b1, 3'd6, 8'h66);
        #1;
        chk("bp_wr_ready", cmd_ready, 1);
        chk("bp_wr_en", mem_en, 1);
        shadow[6] = 8'h66;
        tick();
        drive(1'b1, 1'b0, 3'd4, 8'h00);
        #1;
        chk("bp_rd_blocked", cmd_ready, 0);
        rsp_ready = 1'b1;
        #1;
        chk("bp_reopen", cmd_ready, 1);
        mid(); tick();
        drive(1'b1, 1'b0, 3'd5, 8'h00);
        mid();
        chk("bp_ready2", cmd_ready, 1);
        chk("bp_data2", rsp_data, 8'h12);
        tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        mid(); chk("bp_data3", rsp_data, 8'h14); chk("bp_valid3", rsp_valid, 1); tick();
        mid(); chk("bp_data4", rsp_data, 8'h15); chk("bp_valid4", rsp_valid, 1); tick();
        mid(); chk("bp_idle", idle, 1); chk("bp_empty", rsp_valid, 0);
        tick();

        // fill the FIFO, then stream through it full with pointer wrap
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 3'd0, 8'h00); tick();
        drive(1'b1, 1'b0, 3'd1, 8'h00); tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00); tick();
        rsp_ready = 1'b1;
        for (int j = 0; j < 14; j++) begin
            if (j < 12) drive(1'b1, 1'b0, 3'((j + 2) % 8), 8'h00);
            else        drive(1'b0, 1'b0, 3'd0, 8'h00);
            mid();
            if (j < 12) chk("full_ready", cmd_ready, 1);
            chk("full_valid", rsp_valid, 1);
            chk("full_data", rsp_data, shadow[j % 8]);
            tick();
        end
        mid();
        chk("full_idle", idle, 1);
        tick();

        // read then write same address back-to-back: read sees old data
        drive(1'b1, 1'b0, 3'd5, 8'h00); tick();
        drive(1'b1, 1'b1, 3'd5, 8'h55);
        mid(); chk("rw_wr_ready", cmd_ready, 1); tick();
        drive(1'b1, 1'b0, 3'd5, 8'h00);
        mid(); chk("rw_old_data", rsp_data, 8'h15); chk("rw_old_valid", rsp_valid, 1); tick();
        shadow[5] = 8'h55;
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        mid(); chk("rw_new_data", rsp_data, 8'h55); chk("rw_new_valid", rsp_valid, 1);
        tick();
        do_write(3'd2, 8'h2C);

        // reset with a buffered response and a read in flight
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 3'd2, 8'h00); tick();
        drive(1'b1, 1'b0, 3'd3, 8'h00); tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        mid(); chk("pre_rst_valid", rsp_valid, 1); chk("pre_rst_idle", idle, 0);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 3'd7, 8'h00);
        #1;
        chk("midrst_ready", cmd_ready, 0);
        chk("midrst_en", mem_en, 0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        mid();
        chk("post_rst_valid", rsp_valid, 0);
        chk("post_rst_idle", idle, 1);
        chk("post_rst_data", rsp_data, 0);
        tick();
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 3'd7, 8'h00);
        mid(); chk("post_rst_rd_ready", cmd_ready, 1); tick();
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        mid();
        chk("post_rst_rd_valid", rsp_valid, 1);
        chk("post_rst_rd_data", rsp_data, shadow[7]);
        tick();
        mid();
        chk("final_idle", idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
